// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared constants and sizing helpers for the serial deserializer (frame length depends on SHIFT_DESER_PARITY_EN)
package shift_reg_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int frame_len(input int w);
`ifdef SHIFT_DESER_PARITY_EN
      return w + 1;
`else
      return w;
`endif
   endfunction

endpackage

// File: rtl/shift_deser_out_reg.sv
// shift_deser_out_reg: one-entry valid/ready holding register for {perr, word} with sticky overrun on dropped loads
module shift_deser_out_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [WIDTH:0] load_data,
   input  logic           ready,
   input  logic           ovr_clr,
   output logic [WIDTH:0] data,
   output logic           valid,
   output logic           overrun
);

   logic [WIDTH:0] data_q, data_d;
   logic           valid_q, valid_d;
   logic           overrun_q, overrun_d;
   logic           space;
   logic           take;

   // load when the slot is empty or being drained this cycle; otherwise the word is dropped
   always_comb begin
      space     = ~valid_q | ready;
      take      = load & space;
      data_d    = take ? load_data : data_q;
      valid_d   = take ? 1'b1 : (valid_q & ready) ? 1'b0 : valid_q;
      overrun_d = (load & ~space) | (overrun_q & ~ovr_clr);
   end

   // holding register state
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: rtl/shift_register_deserializer.sv
// shift_register_deserializer: MSB-first serial to parallel receiver with SYNC framing; optional even parity via SHIFT_DESER_PARITY_EN
module shift_register_deserializer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             C,
   input  logic             R,
   input  logic             CE,
   input  logic             SI,
   input  logic             SYNC,
   output logic [WIDTH-1:0] DOUT,
   output logic             DVALID,
   input  logic             DREADY,
   output logic             OVERRUN,
   input  logic             OVR_CLR,
   output logic             PERR
);

   localparam int F  = frame_len(WIDTH);
   localparam int CW = clog2(F);
`ifdef SHIFT_DESER_PARITY_EN
   localparam int SW = WIDTH;
`else
   // the final data bit comes straight from SI, so only WIDTH-1 bits need storing
   localparam int SW = WIDTH - 1;
`endif

   logic [SW-1:0]    sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last;
   logic             done;
   logic [WIDTH-1:0] word;
   logic             perr;
   logic [WIDTH:0]   hold;
`ifdef SHIFT_DESER_PARITY_EN
   logic             par_q, par_d;
`endif

   // shift/count next state; SYNC restarts the frame with SI as its first bit
   always_comb begin
      last  = cnt_q == CW'(F - 1);
      done  = CE & ~SYNC & last;
      sh_d  = !CE ? sh_q : SYNC ? SW'(SI) : SW'({sh_q, SI});
      cnt_d = !CE ? cnt_q : SYNC ? CW'(1) : last ? '0 : cnt_q + CW'(1);
`ifdef SHIFT_DESER_PARITY_EN
      par_d = !CE ? par_q : SYNC ? SI : last ? 1'b0 : par_q ^ SI;
      word  = sh_q;
      perr  = par_q ^ SI;
`else
      word  = {sh_q, SI};
      perr  = 1'b0;
`endif
   end

   // serial capture state
   always_ff @(posedge C) begin
      if (R) begin
         sh_q  <= '0;
         cnt_q <= '0;
`ifdef SHIFT_DESER_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
`ifdef SHIFT_DESER_PARITY_EN
         par_q <= par_d;
`endif
      end
   end

   shift_deser_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk      (C),
      .rst      (R),
      .load     (done),
      .load_data({perr, word}),
      .ready    (DREADY),
      .ovr_clr  (OVR_CLR),
      .data     (hold),
      .valid    (DVALID),
      .overrun  (OVERRUN)
   );

   assign DOUT = hold[WIDTH-1:0];
   assign PERR = hold[WIDTH];

endmodule
